sample_framer: RTL and testbench
================================

SAMPLE_FRAMER -- requirements
Module: sample_framer

Interface
REQ-001 SHALL have parameter SAMPLES, default 128: samples per frame.
REQ-002 SHALL have parameter OSF, default 8: oversampled bits per sample. N = SAMPLES*OSF.
REQ-003 SHALL have port Clock, input, 1 bit: single clock; all logic is rising-edge.
REQ-004 SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port Start, input, 1 bit: begin capture; also clears Overrun.
REQ-006 SHALL have port Continuous, input, 1 bit: 1 = restart capture automatically after each accepted frame.
REQ-007 SHALL have port BitIn, input, 1 bit: oversampled comparator bit.
REQ-008 SHALL have port BitValid, input, 1 bit: BitIn is qualified this cycle.
REQ-009 SHALL have port Frame, output, N bits: assembled frame for the downstream ones-count stage.
REQ-010 SHALL have port FrameValid, output, 1 bit: Frame is complete and stable.
REQ-011 SHALL have port FrameReady, input, 1 bit: consumer accepts Frame.
REQ-012 SHALL have port BitCount, output, $clog2(N)+1 bits: bits captured in the current frame.
REQ-013 SHALL have port Busy, output, 1 bit: high in CAPTURE.
REQ-014 SHALL have port Overrun, output, 1 bit: sticky; a qualified bit was dropped.

Function
REQ-015 SHALL implement an FSM with states IDLE, CAPTURE and HOLD.
REQ-016 IDLE: Start=1 SHALL go to CAPTURE with BitCount=0; other inputs SHALL be ignored.
REQ-017 CAPTURE: each BitValid=1 SHALL write BitIn to Frame[BitCount] and increment BitCount; the k-th bit received (from 0) lands at Frame[k].
REQ-018 CAPTURE: a BitValid on bit N-1 SHALL move the FSM to HOLD; FrameValid SHALL be 1 on the next cycle (latency 1 clock after the last bit).
REQ-019 CAPTURE: BitValid=0 cycles SHALL hold all state; Start SHALL be ignored.
REQ-020 HOLD: Frame, FrameValid=1 and BitCount=N SHALL stay stable until a cycle with FrameReady=1.
REQ-021 HOLD with FrameReady=1: FrameValid SHALL drop next cycle; the next state SHALL be CAPTURE if Continuous=1, otherwise IDLE.
REQ-022 HOLD, FrameReady=1, Continuous=1 and BitValid=1 in the same cycle: the bit SHALL be captured at Frame[0] and BitCount SHALL become 1, so no bit is lost.
REQ-023 HOLD, FrameReady=1, Continuous=0 and BitValid=1 in the same cycle: the bit SHALL be discarded without setting Overrun.
REQ-024 HOLD, FrameReady=0 and BitValid=1: the bit SHALL be discarded, Overrun SHALL be set, and Frame SHALL stay unchanged.
REQ-025 Overrun SHALL be cleared only by Start=1 (sampled in any state) or by reset; a set and a clear in the same cycle SHALL resolve to clear.
REQ-026 Frame bits SHALL NOT be cleared between frames; every position is rewritten before FrameValid rises.
REQ-027 Frame contents SHALL be meaningful only while FrameValid=1.
REQ-028 BitCount SHALL never exceed N and SHALL never wrap.

Reset
REQ-029 Reset_n=0 SHALL immediately force state IDLE and drive Frame=0, FrameValid=0, BitCount=0, Busy=0 and Overrun=0, regardless of the current state.
REQ-030 A reset during CAPTURE or HOLD SHALL abort the frame; after release, capture SHALL resume only on a new Start, at index 0.

Structure
REQ-031 A shared package SHALL hold the state encoding (IDLE, CAPTURE, HOLD) and helpers for N and the BitCount width, reused by the downstream ones-count stage.
REQ-032 The block SHALL be one module with no sub-module; the index counter and the FSM SHALL be inline.

Verification (benches SHALL also run SAMPLES=4, OSF=2, N=8)
REQ-033 Start, then bits 1,0,1,1,0,0,1,0 with BitValid every cycle and FrameReady=0 -> FrameValid=1 one cycle after the 8th bit, Frame=8'b01001101, BitCount=8.
REQ-034 Stall case: HOLD with FrameReady=0 for 5 cycles and 3 BitValid strobes -> Frame unchanged, FrameValid stays 1, Overrun=1; a later Start -> Overrun=0.
REQ-035 Continuous=1, with FrameReady=1 and BitValid=1 (BitIn=1) in the same cycle -> next frame has Frame[0]=1 and BitCount=1 the following cycle; two frames are captured back-to-back with no dropped bits.
REQ-036 Reset_n pulsed low after 3 captured bits, asynchronously mid-cycle -> all outputs 0 at once; after release, Start plus 8 bits produce a correct frame starting at index 0.
REQ-037 BitValid on every third cycle, and Start pulsed during CAPTURE -> the same Frame as REQ-033, Start has no effect, and FrameValid rises one cycle after the last strobe.

Source files
------------

// File: rtl/sample_framer_pkg.sv
// rtl/sample_framer_pkg.sv - shared framer state encoding and size helpers
//
// Purpose: state encoding for the sample framer FSM plus helpers that derive
// the frame length and the bit-count width. The downstream ones-count stage
// imports the same helpers so both sides agree on sizes.
// Ports: none (package).

package sample_framer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_HOLD    = 2'd2
  } framer_state_e;

  // Total oversampled bits in one frame.
  function automatic int frame_bits(input int samples, input int osf);
    return samples * osf;
  endfunction

  // Counter must represent 0..N inclusive, so one bit wider than the index.
  function automatic int count_width(input int n);
    return $clog2(n) + 1;
  endfunction

  // Width of a bit index into the frame (0..N-1).
  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sample_framer.sv
// rtl/sample_framer.sv - assembles oversampled comparator bits into frames
//
// Purpose: captures SAMPLES*OSF qualified bits into a frame register, presents
// the completed frame with a valid/ready handshake, and flags bits dropped
// while a finished frame waits for the consumer.
//
// Ports:
//   Clock       in   rising-edge clock
//   Reset_n     in   asynchronous active-low reset
//   Start       in   begin capture (from IDLE); clears Overrun in any state
//   Continuous  in   re-arm capture automatically after each accepted frame
//   BitIn       in   oversampled comparator bit
//   BitValid    in   BitIn qualifier
//   Frame       out  assembled frame, bit k = k-th bit received
//   FrameValid  out  Frame complete and stable
//   FrameReady  in   consumer accepts Frame
//   BitCount    out  bits captured in the current frame (0..N)
//   Busy        out  high while capturing
//   Overrun     out  sticky, a qualified bit was dropped

module sample_framer
  import sample_framer_pkg::*;
#(
  parameter int SAMPLES = 128,
  parameter int OSF     = 8
) (
  input  logic                                            Clock,
  input  logic                                            Reset_n,
  input  logic                                            Start,
  input  logic                                            Continuous,
  input  logic                                            BitIn,
  input  logic                                            BitValid,
  output logic [frame_bits(SAMPLES, OSF)-1:0]             Frame,
  output logic                                            FrameValid,
  input  logic                                            FrameReady,
  output logic [count_width(frame_bits(SAMPLES, OSF))-1:0] BitCount,
  output logic                                            Busy,
  output logic                                            Overrun
);

  localparam int N  = frame_bits(SAMPLES, OSF);
  localparam int CW = count_width(N);
  localparam int IW = index_width(N);

  framer_state_e   state_q;
  logic [N-1:0]    frame_q;
  logic [CW-1:0]   count_q;
  logic            fvalid_q;
  logic            busy_q;
  logic            overrun_q;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= ST_IDLE;
      frame_q   <= '0;
      count_q   <= '0;
      fvalid_q  <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            state_q <= ST_CAPTURE;
            count_q <= '0;
            busy_q  <= 1'b1;
          end
        end

        ST_CAPTURE: begin
          // Start is deliberately ignored here; idle cycles hold everything.
          if (BitValid) begin
            frame_q[count_q[IW-1:0]] <= BitIn;
            count_q                  <= count_q + CW'(1);
            if (count_q == CW'(N - 1)) begin
              state_q  <= ST_HOLD;
              fvalid_q <= 1'b1;
              busy_q   <= 1'b0;
            end
          end
        end

        ST_HOLD: begin
          if (FrameReady) begin
            fvalid_q <= 1'b0;
            if (Continuous) begin
              // A bit arriving on the accept cycle opens the next frame so
              // back-to-back streams lose nothing.
              state_q <= ST_CAPTURE;
              busy_q  <= 1'b1;
              if (BitValid) begin
                frame_q[0] <= BitIn;
                count_q    <= CW'(1);
              end else begin
                count_q    <= '0;
              end
            end else begin
              // Non-continuous accept: a coincident bit is simply discarded.
              state_q <= ST_IDLE;
              count_q <= '0;
            end
          end else if (BitValid) begin
            overrun_q <= 1'b1;
          end
        end

        default: begin
          state_q  <= ST_IDLE;
          count_q  <= '0;
          fvalid_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase

      // Later assignment wins: a clear on the same cycle as a set resolves to clear.
      if (Start) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign Frame      = frame_q;
  assign FrameValid = fvalid_q;
  assign BitCount   = count_q;
  assign Busy       = busy_q;
  assign Overrun    = overrun_q;

endmodule

// File: tb/tb_sample_framer.sv
// tb/tb_sample_framer.sv - directed self-checking bench for sample_framer (N=8)

module tb_sample_framer;

  logic       Clock;
  logic       Reset_n;
  logic       Start;
  logic       Continuous;
  logic       BitIn;
  logic       BitValid;
  logic [7:0] Frame;
  logic       FrameValid;
  logic       FrameReady;
  logic [3:0] BitCount;
  logic       Busy;
  logic       Overrun;

  int checks = 0;
  int errors = 0;

  localparam logic [7:0] P1 = 8'b0100_1101;  // bits 1,0,1,1,0,0,1,0
  localparam logic [7:0] P2 = 8'hA7;         // bits 1,1,1,0,0,1,0,1
  localparam logic [7:0] P3 = 8'h16;         // bits 0,1,1,0,1,0,0,0

  logic [7:0] pat;

  sample_framer #(.SAMPLES(4), .OSF(2)) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .Start      (Start),
    .Continuous (Continuous),
    .BitIn      (BitIn),
    .BitValid   (BitValid),
    .Frame      (Frame),
    .FrameValid (FrameValid),
    .FrameReady (FrameReady),
    .BitCount   (BitCount),
    .Busy       (Busy),
    .Overrun    (Overrun)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    Reset_n = 1'b0; Start = 1'b0; Continuous = 1'b0; BitIn = 1'b0;
    BitValid = 1'b0; FrameReady = 1'b0;
    #12;
    check("rst_frame", 32'(Frame), 32'h0);
    check("rst_fvalid", 32'(FrameValid), 32'h0);
    check("rst_count", 32'(BitCount), 32'h0);
    check("rst_busy", 32'(Busy), 32'h0);
    check("rst_overrun", 32'(Overrun), 32'h0);
    Reset_n = 1'b1;
    tick();

    // Basic frame, BitValid every cycle
    Start = 1'b1; tick(); Start = 1'b0;
    check("a_busy", 32'(Busy), 32'h1);
    check("a_count0", 32'(BitCount), 32'h0);
    pat = P1;
    for (int i = 0; i < 8; i++) begin
      BitIn = pat[i]; BitValid = 1'b1; tick();
      if (i == 6) begin
        check("a_count7", 32'(BitCount), 32'h7);
        check("a_fv_early", 32'(FrameValid), 32'h0);
      end
    end
    BitValid = 1'b0;
    check("a_fv", 32'(FrameValid), 32'h1);
    check("a_frame", 32'(Frame), 32'h4D);
    check("a_count8", 32'(BitCount), 32'h8);
    check("a_busy_hold", 32'(Busy), 32'h0);
    tick(); tick();
    check("a_frame_stable", 32'(Frame), 32'h4D);
    check("a_fv_stable", 32'(FrameValid), 32'h1);
    // Accept with a coincident bit, not continuous: bit discarded, no overrun
    FrameReady = 1'b1; BitValid = 1'b1; BitIn = 1'b1; tick();
    FrameReady = 1'b0; BitValid = 1'b0;
    check("a_fv_drop", 32'(FrameValid), 32'h0);
    check("a_no_overrun", 32'(Overrun), 32'h0);
    check("a_idle_busy", 32'(Busy), 32'h0);
    check("a_idle_count", 32'(BitCount), 32'h0);
    BitValid = 1'b1; tick(); BitValid = 1'b0;
    check("idle_ignore_count", 32'(BitCount), 32'h0);
    check("idle_ignore_busy", 32'(Busy), 32'h0);

    // Sparse strobes every third cycle, Start pulsed mid-capture
    Start = 1'b1; tick(); Start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      Start = (i == 3); tick(); Start = 1'b0;
      tick();
      if (i == 7) begin
        check("b_fv_before", 32'(FrameValid), 32'h0);
        check("b_count7", 32'(BitCount), 32'h7);
      end
      BitIn = pat[i]; BitValid = 1'b1; tick(); BitValid = 1'b0;
      if (i == 3) check("b_start_ignored", 32'(BitCount), 32'h4);
    end
    check("b_fv", 32'(FrameValid), 32'h1);
    check("b_frame", 32'(Frame), 32'h4D);
    check("b_count8", 32'(BitCount), 32'h8);

    // Stall: 5 cycles FrameReady=0 with 3 strobes
    for (int c = 0; c < 5; c++) begin
      BitValid = (c % 2 == 0); BitIn = ~pat[c]; tick();
    end
    BitValid = 1'b0;
    check("c_frame", 32'(Frame), 32'h4D);
    check("c_fv", 32'(FrameValid), 32'h1);
    check("c_overrun", 32'(Overrun), 32'h1);
    check("c_count", 32'(BitCount), 32'h8);
    // Set and clear on the same cycle: clear wins
    Start = 1'b1; BitValid = 1'b1; tick(); Start = 1'b0; BitValid = 1'b0;
    check("c_overrun_clr", 32'(Overrun), 32'h0);
    check("c_fv_after_start", 32'(FrameValid), 32'h1);
    check("c_busy", 32'(Busy), 32'h0);

    // Continuous back-to-back frames
    Continuous = 1'b1;
    pat = P2;
    FrameReady = 1'b1; BitValid = 1'b1; BitIn = pat[0]; tick(); FrameReady = 1'b0;
    check("d_fv_drop", 32'(FrameValid), 32'h0);
    check("d_count1", 32'(BitCount), 32'h1);
    check("d_bit0", 32'(Frame[0]), 32'h1);
    check("d_busy", 32'(Busy), 32'h1);
    for (int i = 1; i < 8; i++) begin
      BitIn = pat[i]; tick();
    end
    check("d_fv2", 32'(FrameValid), 32'h1);
    check("d_frame2", 32'(Frame), 32'hA7);
    pat = P3;
    FrameReady = 1'b1; BitIn = pat[0]; tick(); FrameReady = 1'b0;
    check("d_count1b", 32'(BitCount), 32'h1);
    for (int i = 1; i < 8; i++) begin
      BitIn = pat[i]; tick();
    end
    BitValid = 1'b0;
    check("d_fv3", 32'(FrameValid), 32'h1);
    check("d_frame3", 32'(Frame), 32'h16);
    check("d_overrun", 32'(Overrun), 32'h0);
    Continuous = 1'b0; FrameReady = 1'b1; tick(); FrameReady = 1'b0;
    check("d_end_fv", 32'(FrameValid), 32'h0);
    check("d_end_busy", 32'(Busy), 32'h0);

    // Asynchronous reset after 3 captured bits
    Start = 1'b1; tick(); Start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      BitIn = 1'b1; BitValid = 1'b1; tick();
    end
    BitValid = 1'b0;
    check("e_count3", 32'(BitCount), 32'h3);
    #2 Reset_n = 1'b0;
    #1;
    check("e_frame", 32'(Frame), 32'h0);
    check("e_fv", 32'(FrameValid), 32'h0);
    check("e_count", 32'(BitCount), 32'h0);
    check("e_busy", 32'(Busy), 32'h0);
    check("e_overrun", 32'(Overrun), 32'h0);
    #2 Reset_n = 1'b1;
    BitValid = 1'b1; BitIn = 1'b1; tick(); BitValid = 1'b0;
    check("e_idle_count", 32'(BitCount), 32'h0);
    check("e_idle_busy", 32'(Busy), 32'h0);
    pat = P1;
    Start = 1'b1; tick(); Start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      BitIn = pat[i]; BitValid = 1'b1; tick();
    end
    BitValid = 1'b0;
    check("e_frame_after", 32'(Frame), 32'h4D);
    check("e_count_after", 32'(BitCount), 32'h8);
    check("e_fv_after", 32'(FrameValid), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
